itrx_aib_phy_nchan_rst_seq: RTL and testbench

Parametrised, multi-channel AIB link bring-up sequencer that sits beside NCHAN AIB PHY instances. Per channel it performs these steps in order:
- debounces device detect
- releases the local PHY reset (adapt_rstn)
- runs the ms/sl rstn and adapter-rstn handshake with the link partner, in master or slave ordering
- reports ready or timeout error
It replaces static, externally driven reset pins with an autonomous, timed, per-channel FSM.

---
 rtl/itrx_aib_phy_rst_seq_pkg.sv | 23 ++
 rtl/itrx_aib_phy_rst_seq_chan.sv | 178 +++++++++++++++++
 rtl/itrx_aib_phy_nchan_rst_seq.sv | 68 ++++++
 tb/tb_itrx_aib_phy_nchan_rst_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itrx_aib_phy_rst_seq_pkg.sv
// Shared definitions for the AIB per-channel bring-up sequencer.
package itrx_aib_phy_rst_seq_pkg;

    localparam int ST_W = 3;

    // Per-channel bring-up state; the encoding is visible on the debug bus.
    typedef enum logic [ST_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DET = 3'd1,
        ST_REL_PHY  = 3'd2,
        ST_REL_RSTN = 3'd3,
        ST_REL_ADAP = 3'd4,
        ST_READY    = 3'd5,
        ST_ERR      = 3'd6,
        ST_ILLEGAL  = 3'd7
    } chan_state_e;

    // Packs one channel state into its field of the debug bus.
    function automatic logic [ST_W-1:0] dbg_field(input chan_state_e st);
        return st;
    endfunction

endpackage

// File: rtl/itrx_aib_phy_rst_seq_chan.sv
// One AIB channel: input synchronisers, delay/timeout counter and bring-up FSM.
module itrx_aib_phy_rst_seq_chan
    import itrx_aib_phy_rst_seq_pkg::*;
#(
    parameter int              CNTW    = 16,
    parameter logic [CNTW-1:0] DET_DLY = 16'd64,
    parameter logic [CNTW-1:0] RST_DLY = 16'd32,
    parameter logic [CNTW-1:0] TMO     = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ms_nsl,
    input  logic            chan_en,
    input  logic            device_detect,
    input  logic            rstn_in,
    input  logic            adap_rstn_in,
    output logic            adapt_rstn,
    output logic            rstn_out,
    output logic            adap_rstn_out,
    output logic            chan_ready,
    output logic            chan_err,
    output logic [ST_W-1:0] state_dbg
);

    localparam logic [CNTW-1:0] DET_LAST = DET_DLY - CNTW'(1);
    localparam logic [CNTW-1:0] RST_LAST = RST_DLY - CNTW'(1);
    localparam logic [CNTW-1:0] TMO_LAST = TMO - CNTW'(1);

    // Synchroniser bit order: {device_detect, rstn_in, adap_rstn_in}.
    logic [2:0] sync1_d, sync1_q, sync2_d, sync2_q;
    logic       det_s, rstn_in_s, adap_rstn_in_s;

    chan_state_e     state_d, state_q;
    logic [CNTW-1:0] cnt_d, cnt_q, cnt_inc;
    logic            adapt_rstn_d, adapt_rstn_q;
    logic            rstn_out_d, rstn_out_q;
    logic            adap_rstn_out_d, adap_rstn_out_q;
    logic            chan_ready_d, chan_ready_q;
    logic            chan_err_d, chan_err_q;

    // Two-stage synchroniser next values for the asynchronous pins.
    always_comb begin
        sync1_d = {device_detect, rstn_in, adap_rstn_in};
        sync2_d = sync1_q;
    end

    assign det_s          = sync2_q[2];
    assign rstn_in_s      = sync2_q[1];
    assign adap_rstn_in_s = sync2_q[0];

    // Next state and counter; abort on chan_en=0 overrides everything else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);
        case (state_q)
            ST_IDLE: begin
                if (chan_en) begin
                    state_d = ST_WAIT_DET;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_DET: begin
                if (!det_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DET_LAST) begin
                    state_d = ST_REL_PHY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REL_PHY: begin
                if (!det_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_d = ST_REL_RSTN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REL_RSTN: begin
                if (!det_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (rstn_in_s) begin
                    state_d = ST_REL_ADAP;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REL_ADAP: begin
                if (!det_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (adap_rstn_in_s) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_READY: begin
                if (!det_s || !rstn_in_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (state_q != ST_IDLE && !chan_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Output decode from the next state so each output flop switches on the
    // same edge as the state register. In slave ordering the local releases
    // are echoes, which makes them follow the partner by one state step.
    always_comb begin
        adapt_rstn_d    = (state_d == ST_REL_PHY) || (state_d == ST_REL_RSTN) ||
                          (state_d == ST_REL_ADAP) || (state_d == ST_READY);
        rstn_out_d      = (state_d == ST_REL_ADAP) || (state_d == ST_READY) ||
                          ((state_d == ST_REL_RSTN) && ms_nsl);
        adap_rstn_out_d = (state_d == ST_READY) ||
                          ((state_d == ST_REL_ADAP) && ms_nsl);
        chan_ready_d    = (state_d == ST_READY);
        chan_err_d      = (state_d == ST_ERR);
    end

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            adapt_rstn_q    <= 1'b0;
            rstn_out_q      <= 1'b0;
            adap_rstn_out_q <= 1'b0;
            chan_ready_q    <= 1'b0;
            chan_err_q      <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            adapt_rstn_q    <= adapt_rstn_d;
            rstn_out_q      <= rstn_out_d;
            adap_rstn_out_q <= adap_rstn_out_d;
            chan_ready_q    <= chan_ready_d;
            chan_err_q      <= chan_err_d;
        end
    end

    assign adapt_rstn    = adapt_rstn_q;
    assign rstn_out      = rstn_out_q;
    assign adap_rstn_out = adap_rstn_out_q;
    assign chan_ready    = chan_ready_q;
    assign chan_err      = chan_err_q;
    assign state_dbg     = dbg_field(state_q);

endmodule

// File: rtl/itrx_aib_phy_nchan_rst_seq.sv
// NCHAN independent AIB bring-up sequencers plus the aggregate link-up flag.
module itrx_aib_phy_nchan_rst_seq
    import itrx_aib_phy_rst_seq_pkg::*;
#(
    parameter int              NCHAN   = 4,
    parameter int              CNTW    = 16,
    parameter logic [CNTW-1:0] DET_DLY = 16'd64,
    parameter logic [CNTW-1:0] RST_DLY = 16'd32,
    parameter logic [CNTW-1:0] TMO     = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ms_nsl,
    input  logic [NCHAN-1:0]      chan_en,
    input  logic [NCHAN-1:0]      device_detect,
    input  logic [NCHAN-1:0]      rstn_in,
    input  logic [NCHAN-1:0]      adap_rstn_in,
    output logic [NCHAN-1:0]      adapt_rstn,
    output logic [NCHAN-1:0]      rstn_out,
    output logic [NCHAN-1:0]      adap_rstn_out,
    output logic [NCHAN-1:0]      chan_ready,
    output logic [NCHAN-1:0]      chan_err,
    output logic                  all_ready,
    output logic [ST_W*NCHAN-1:0] state_dbg
);

    logic all_ready_d, all_ready_q;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        itrx_aib_phy_rst_seq_chan #(
            .CNTW    (CNTW),
            .DET_DLY (DET_DLY),
            .RST_DLY (RST_DLY),
            .TMO     (TMO)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .ms_nsl        (ms_nsl),
            .chan_en       (chan_en[g]),
            .device_detect (device_detect[g]),
            .rstn_in       (rstn_in[g]),
            .adap_rstn_in  (adap_rstn_in[g]),
            .adapt_rstn    (adapt_rstn[g]),
            .rstn_out      (rstn_out[g]),
            .adap_rstn_out (adap_rstn_out[g]),
            .chan_ready    (chan_ready[g]),
            .chan_err      (chan_err[g]),
            .state_dbg     (state_dbg[g*ST_W +: ST_W])
        );
    end

    // Link up when every enabled channel is ready and at least one is enabled.
    always_comb begin
        all_ready_d = (|chan_en) & (&(chan_ready | ~chan_en));
    end

    // Registered aggregate, one cycle behind chan_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_ready_q <= 1'b0;
        end else begin
            all_ready_q <= all_ready_d;
        end
    end

    assign all_ready = all_ready_q;

endmodule

// File: tb/tb_itrx_aib_phy_nchan_rst_seq.sv
// Bench for the NCHAN AIB bring-up sequencer: a stimulus process drives
// partner behaviour and events, a reference model predicts each cycle's
// outputs into a queue, and a monitor pops and compares.
module tb_itrx_aib_phy_nchan_rst_seq;

    localparam int NCHAN = 4;
    localparam int CNTW  = 16;
    localparam int DETV  = 64;
    localparam int RSTV  = 32;
    localparam int TMOV  = 100;
    localparam int W     = 8*NCHAN + 1;

    // State encodings as visible on the debug bus.
    localparam int S_IDLE = 0, S_WAIT = 1, S_PHY = 2, S_RSTN = 3;
    localparam int S_ADAP = 4, S_READY = 5, S_ERR = 6;

    logic                 clk, rst, ms_nsl;
    logic [NCHAN-1:0]     chan_en, device_detect, rstn_in, adap_rstn_in;
    logic [NCHAN-1:0]     adapt_rstn, rstn_out, adap_rstn_out, chan_ready, chan_err;
    logic                 all_ready;
    logic [3*NCHAN-1:0]   state_dbg;

    itrx_aib_phy_nchan_rst_seq #(
        .NCHAN(NCHAN), .CNTW(CNTW), .DET_DLY(16'd64), .RST_DLY(16'd32), .TMO(16'd100)
    ) dut (
        .clk(clk), .rst(rst), .ms_nsl(ms_nsl), .chan_en(chan_en),
        .device_detect(device_detect), .rstn_in(rstn_in), .adap_rstn_in(adap_rstn_in),
        .adapt_rstn(adapt_rstn), .rstn_out(rstn_out), .adap_rstn_out(adap_rstn_out),
        .chan_ready(chan_ready), .chan_err(chan_err), .all_ready(all_ready),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mid_q[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;
    int  cyc = 0;
    bit  done = 0;

    // ---------------- reference model ----------------
    int  m_st[NCHAN];
    int  m_cnt[NCHAN];
    bit  det_p[NCHAN], det_s[NCHAN];
    bit  ri_p[NCHAN],  ri_s[NCHAN];
    bit  ai_p[NCHAN],  ai_s[NCHAN];
    bit  m_all;

    function automatic bit m_adapt(int st);
        return st >= S_PHY && st <= S_READY;
    endfunction
    function automatic bit m_rstn(int st, bit ms);
        return st == S_ADAP || st == S_READY || (st == S_RSTN && ms);
    endfunction
    function automatic bit m_adap(int st, bit ms);
        return st == S_READY || (st == S_ADAP && ms);
    endfunction

    task automatic model_step(input bit r, input logic [NCHAN-1:0] en,
                              input logic [NCHAN-1:0] det, input logic [NCHAN-1:0] ri,
                              input logic [NCHAN-1:0] ai);
        bit all_ok;
        if (r) begin
            for (int c = 0; c < NCHAN; c++) begin
                m_st[c] = S_IDLE; m_cnt[c] = 0;
                det_p[c] = 0; det_s[c] = 0; ri_p[c] = 0; ri_s[c] = 0; ai_p[c] = 0; ai_s[c] = 0;
            end
            m_all = 0;
            return;
        end
        all_ok = 1;
        for (int c = 0; c < NCHAN; c++)
            if (en[c] && m_st[c] != S_READY) all_ok = 0;
        m_all = (en != 0) && all_ok;
        for (int c = 0; c < NCHAN; c++) begin
            int st, ct;
            st = m_st[c]; ct = m_cnt[c];
            if (st != S_IDLE && !en[c]) begin
                st = S_IDLE; ct = 0;
            end else if (st == S_IDLE) begin
                if (en[c]) begin st = S_WAIT; ct = 0; end
            end else if (st == S_WAIT) begin
                if (!det_s[c]) ct = 0;
                else if (ct == DETV-1) begin st = S_PHY; ct = 0; end
                else ct++;
            end else if (st == S_ERR) begin
                st = S_ERR;
            end else if (!det_s[c]) begin
                st = S_IDLE; ct = 0;
            end else if (st == S_PHY) begin
                if (ct == RSTV-1) begin st = S_RSTN; ct = 0; end
                else ct++;
            end else if (st == S_RSTN) begin
                if (ri_s[c]) begin st = S_ADAP; ct = 0; end
                else if (ct == TMOV-1) begin st = S_ERR; ct = 0; end
                else ct++;
            end else if (st == S_ADAP) begin
                if (ai_s[c]) begin st = S_READY; ct = 0; end
                else if (ct == TMOV-1) begin st = S_ERR; ct = 0; end
                else ct++;
            end else if (st == S_READY) begin
                if (!ri_s[c]) begin st = S_IDLE; ct = 0; end
            end
            m_st[c] = st; m_cnt[c] = ct;
            det_s[c] = det_p[c]; det_p[c] = det[c];
            ri_s[c]  = ri_p[c];  ri_p[c]  = ri[c];
            ai_s[c]  = ai_p[c];  ai_p[c]  = ai[c];
        end
    endtask

    function automatic logic [W-1:0] model_exp(bit ms);
        logic [W-1:0] v;
        logic [2:0]   s3;
        v = '0;
        for (int c = 0; c < NCHAN; c++) begin
            s3 = 3'(m_st[c]);
            v[c]            = m_adapt(m_st[c]);
            v[NCHAN+c]      = m_rstn(m_st[c], ms);
            v[2*NCHAN+c]    = m_adap(m_st[c], ms);
            v[3*NCHAN+c]    = (m_st[c] == S_READY);
            v[4*NCHAN+c]    = (m_st[c] == S_ERR);
            v[5*NCHAN+3*c +: 3] = s3;
        end
        v[8*NCHAN] = m_all;
        return v;
    endfunction

    // ---------------- stimulus state ----------------
    bit  ms;
    bit  en_base[NCHAN], det_base[NCHAN], dead[NCHAN];
    int  pd[NCHAN], r_run[NCHAN], a_run[NCHAN];
    int  glitch_cnt[NCHAN], loss_cnt[NCHAN], off_cnt[NCHAN];
    int  rst_hold;
    bit  arst_req;

    // One clock of stimulus: partner echoes, events, model step, expectation.
    task automatic drive_cycle(input bit rnd);
        logic [NCHAN-1:0] en_v, det_v, ri_v, ai_v;
        bit src_r, src_a;
        @(negedge clk);
        cyc++;
        for (int c = 0; c < NCHAN; c++) begin
            if (rnd) begin
                if ($urandom_range(0, 299) == 0) glitch_cnt[c] = $urandom_range(1, 3);
                if ($urandom_range(0, 399) == 0) loss_cnt[c]   = $urandom_range(1, 5);
                if ($urandom_range(0, 499) == 0) off_cnt[c]    = $urandom_range(1, 3);
            end
            src_r = ms ? m_rstn(m_st[c], ms) : m_adapt(m_st[c]);
            src_a = ms ? m_adap(m_st[c], ms) : m_rstn(m_st[c], ms);
            r_run[c] = src_r ? r_run[c] + 1 : 0;
            a_run[c] = src_a ? a_run[c] + 1 : 0;
            en_v[c]  = en_base[c] && off_cnt[c] == 0;
            det_v[c] = det_base[c] && glitch_cnt[c] == 0;
            ri_v[c]  = !dead[c] && r_run[c] >= pd[c] && loss_cnt[c] == 0;
            ai_v[c]  = !dead[c] && a_run[c] >= pd[c];
            if (glitch_cnt[c] > 0) glitch_cnt[c]--;
            if (loss_cnt[c] > 0)   loss_cnt[c]--;
            if (off_cnt[c] > 0)    off_cnt[c]--;
        end
        chan_en = en_v; device_detect = det_v; rstn_in = ri_v; adap_rstn_in = ai_v;
        ms_nsl = ms;
        if (arst_req) begin
            arst_req = 0;
            rst_hold = 1;
            #2;
            rst = 1'b1;
            mid_q.push_back('0);
            model_step(1, en_v, det_v, ri_v, ai_v);
        end else if (rst_hold > 0) begin
            rst_hold--;
            rst = 1'b1;
            model_step(1, en_v, det_v, ri_v, ai_v);
        end else begin
            rst = 1'b0;
            model_step(0, en_v, det_v, ri_v, ai_v);
        end
        exp_q.push_back(model_exp(ms));
    endtask

    // Disable every channel long enough for all FSMs to sit in IDLE.
    task automatic go_idle();
        for (int c = 0; c < NCHAN; c++) begin
            en_base[c] = 0; glitch_cnt[c] = 0; loss_cnt[c] = 0; off_cnt[c] = 0;
        end
        repeat (4) drive_cycle(0);
    endtask

    task automatic run_seg(input int ncyc, input bit rnd, input bit do_arst);
        bit armed;
        armed = do_arst;
        for (int i = 0; i < ncyc; i++) begin
            if (armed) begin
                for (int c = 0; c < NCHAN; c++)
                    if (m_st[c] == S_ADAP) armed = 0;
                if (!armed) arst_req = 1;
            end
            drive_cycle(rnd);
        end
    endtask

    // ---------------- driver ----------------
    initial begin
        rst = 1'b1; ms = 1'b1; ms_nsl = 1'b1;
        chan_en = '0; device_detect = '0; rstn_in = '0; adap_rstn_in = '0;
        arst_req = 0; rst_hold = 3;
        for (int c = 0; c < NCHAN; c++) begin
            en_base[c] = 0; det_base[c] = 0; dead[c] = 0; pd[c] = 10;
            r_run[c] = 0; a_run[c] = 0; glitch_cnt[c] = 0; loss_cnt[c] = 0; off_cnt[c] = 0;
        end
        model_step(1, '0, '0, '0, '0);
        repeat (4) drive_cycle(0);

        // Master ordering, channel 0 only, partner echo after 10 cycles.
        en_base[0] = 1; det_base[0] = 1;
        run_seg(260, 0, 0);
        go_idle();

        // Detect glitch on channel 0 while the debounce count is mid-way.
        en_base[0] = 1;
        run_seg(42, 0, 0);
        glitch_cnt[0] = 1;
        run_seg(200, 0, 0);
        go_idle();

        // Slave ordering: ch1 normal, ch2 link loss in READY, ch3 dead partner.
        ms = 0;
        for (int c = 0; c < NCHAN; c++) begin
            en_base[c] = 1; det_base[c] = 1; pd[c] = 5 + 3*c; dead[c] = (c == 3);
        end
        run_seg(400, 0, 0);
        loss_cnt[2] = 1;
        run_seg(100, 0, 0);
        off_cnt[3] = 2;
        run_seg(300, 0, 0);
        go_idle();

        // Randomised segments; some end in an asynchronous reset mid-handshake.
        for (int s = 0; s < 12; s++) begin
            ms = 1'($urandom_range(0, 1));
            for (int c = 0; c < NCHAN; c++) begin
                en_base[c]  = 1'($urandom_range(0, 3) != 0);
                det_base[c] = en_base[c] || ($urandom_range(0, 1) == 1);
                dead[c]     = ($urandom_range(0, 5) == 0);
                pd[c]       = $urandom_range(1, 20);
            end
            run_seg(500, 1, (s % 3) == 1);
            go_idle();
        end

        // All channels through REL_ADAP, then asynchronous reset.
        ms = 1;
        for (int c = 0; c < NCHAN; c++) begin
            en_base[c] = 1; det_base[c] = 1; dead[c] = 0; pd[c] = 30;
        end
        run_seg(300, 0, 1);
        run_seg(20, 0, 0);
        done = 1;
    end

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] got, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {all_ready, state_dbg, chan_err, chan_ready, adap_rstn_out, rstn_out, adapt_rstn};
                total_cnt++;
                if (got === e) pass_cnt++;
                else $display("FAIL out_vec cycle %0d: got %h expected %h", cyc, got, e);
            end
            @(negedge clk);
            #4;
            if (mid_q.size() > 0) begin
                e   = mid_q.pop_front();
                got = {all_ready, state_dbg, chan_err, chan_ready, adap_rstn_out, rstn_out, adapt_rstn};
                total_cnt++;
                if (got === e) pass_cnt++;
                else $display("FAIL async_rst_outputs cycle %0d: got %h expected %h", cyc, got, e);
            end
            if (done && exp_q.size() == 0 && mid_q.size() == 0) begin
                $display("%0d/%0d checks passed", pass_cnt, total_cnt);
                $finish;
            end
        end
    end

endmodule
